// File: rtl/mor1kx_pic_irq_sched.sv
// Picks one pending PICSR line, requests it from the CPU, tracks ack/EOI and clears the serviced bit via one SPR write.
// Fixed priority by default; define PIC_SCHED_RR_EN for round-robin. irq_o follows a pending bit by 1 cycle; the SPR write holds until spr_bus_ack.
module mor1kx_pic_irq_sched #(
  parameter logic [15:0] PICSR_ADDR   = 16'h4802,
  parameter bit          CLEAR_ON_EOI = 1'b1,
  parameter int          SPUR_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           picsr_i,
  output logic                  irq_o,
  output logic [4:0]            irq_id_o,
  input  logic                  irq_ack_i,
  input  logic                  eoi_i,
  output logic                  busy_o,
  output logic                  spr_access_o,
  output logic                  spr_we_o,
  output logic [15:0]           spr_addr_o,
  output logic [31:0]           spr_dat_o,
  input  logic                  spr_bus_ack_i,
  output logic [SPUR_CNT_W-1:0] spur_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] win_id;
  logic       pending;
  logic       grant;
  logic       withdraw;

  assign pending  = |picsr_i;
  assign grant    = (state == S_IDLE) && pending;
  // Ack beats a same-cycle bit drop, so only an un-acked drop counts as withdrawn.
  assign withdraw = (state == S_REQ) && !irq_ack_i && !picsr_i[irq_id_o];

`ifdef PIC_SCHED_RR_EN
  logic [4:0] rr_ptr;
  logic [4:0] rr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= win_id + 5'd1;
    end
  end

  // Walk offsets high to low so the smallest offset from rr_ptr is the last assignment.
  always_comb begin
    win_id = '0;
    rr_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      rr_idx = rr_ptr + 5'(i);
      if (picsr_i[rr_idx]) begin
        win_id = rr_idx;
      end
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = 31; i >= 0; i--) begin
      if (picsr_i[i]) begin
        win_id = 5'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack_i) begin
          state_nxt = S_SERVICE;
        end else if (withdraw) begin
          state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi_i) begin
          state_nxt = CLEAR_ON_EOI ? S_CLEAR : S_IDLE;
        end
      end
      S_CLEAR: begin
        if (spr_bus_ack_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    irq_o        = 1'b0;
    busy_o       = (state != S_IDLE);
    spr_access_o = 1'b0;
    spr_we_o     = 1'b0;
    spr_addr_o   = '0;
    spr_dat_o    = '0;
    case (state)
      S_REQ: begin
        irq_o = 1'b1;
      end
      S_CLEAR: begin
        spr_access_o = 1'b1;
        spr_we_o     = 1'b1;
        spr_addr_o   = PICSR_ADDR;
        spr_dat_o    = 32'd1 << irq_id_o;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_id_o <= '0;
    end else if (grant) begin
      irq_id_o <= win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spur_cnt_o <= '0;
    end else if (withdraw && !(&spur_cnt_o)) begin
      spur_cnt_o <= spur_cnt_o + SPUR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mor1kx_pic_irq_sched.sv
// Bench for mor1kx_pic_irq_sched: table vectors, directed corner sequences and a random run against a reference model.
module tb_mor1kx_pic_irq_sched;

  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SVC  = 2;
  localparam int S_CLR  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] picsr;
  logic        ack, eoi, bak;

  logic        irq, busy, acc, we;
  logic [4:0]  irq_id;
  logic [15:0] addr;
  logic [31:0] dat;
  logic [15:0] spur;

  logic        n_irq, n_busy, n_acc, n_we;
  logic [4:0]  n_id;
  logic [15:0] n_addr;
  logic [31:0] n_dat;
  logic [1:0]  n_spur;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mor1kx_pic_irq_sched dut (
    .clk(clk), .rst(rst), .picsr_i(picsr), .irq_o(irq), .irq_id_o(irq_id),
    .irq_ack_i(ack), .eoi_i(eoi), .busy_o(busy), .spr_access_o(acc), .spr_we_o(we),
    .spr_addr_o(addr), .spr_dat_o(dat), .spr_bus_ack_i(bak), .spur_cnt_o(spur)
  );

  mor1kx_pic_irq_sched #(.CLEAR_ON_EOI(1'b0), .SPUR_CNT_W(2)) dut_ne (
    .clk(clk), .rst(rst), .picsr_i(picsr), .irq_o(n_irq), .irq_id_o(n_id),
    .irq_ack_i(ack), .eoi_i(eoi), .busy_o(n_busy), .spr_access_o(n_acc), .spr_we_o(n_we),
    .spr_addr_o(n_addr), .spr_dat_o(n_dat), .spr_bus_ack_i(bak), .spur_cnt_o(n_spur)
  );

  typedef struct {
    int st;
    int id;
    int cnt;
    int ptr;
  } m_t;

  m_t m0, m1;

  function automatic int pick(input logic [31:0] p, input int start);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (start + k) % 32;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  function automatic m_t m_next(input m_t s, input bit coe, input int cmax);
    m_t n;
    n = s;
    if (rst) begin
      n = '{S_IDLE, 0, 0, 0};
      return n;
    end
    case (s.st)
      S_IDLE: if (picsr != 0) begin
`ifdef PIC_SCHED_RR_EN
        n.id  = pick(picsr, s.ptr);
        n.ptr = (n.id + 1) % 32;
`else
        n.id  = pick(picsr, 0);
`endif
        n.st = S_REQ;
      end
      S_REQ: begin
        if (ack) n.st = S_SVC;
        else if (!picsr[s.id]) begin
          n.st  = S_IDLE;
          n.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
        end
      end
      S_SVC: if (eoi) n.st = coe ? S_CLR : S_IDLE;
      default: if (bak) n.st = S_IDLE;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string t, input m_t m, input logic i_irq, input logic [4:0] i_id,
                         input logic i_busy, input logic i_acc, input logic i_we,
                         input logic [15:0] i_addr, input logic [31:0] i_dat, input int i_spur);
    bit clr;
    clr = (m.st == S_CLR);
    check({t, "_irq"},  32'(i_irq),  32'(m.st == S_REQ));
    check({t, "_id"},   32'(i_id),   32'(m.id));
    check({t, "_busy"}, 32'(i_busy), 32'(m.st != S_IDLE));
    check({t, "_acc"},  32'(i_acc),  32'(clr));
    check({t, "_we"},   32'(i_we),   32'(clr));
    check({t, "_addr"}, 32'(i_addr), clr ? 32'h4802 : 32'h0);
    check({t, "_dat"},  i_dat,       clr ? (32'h1 << m.id) : 32'h0);
    check({t, "_spur"}, 32'(i_spur), 32'(m.cnt));
  endtask

  // One clock: advance both models on the current inputs, then compare both DUTs at the falling edge.
  task automatic cyc();
    m0 = m_next(m0, 1'b1, 65535);
    m1 = m_next(m1, 1'b0, 3);
    @(posedge clk);
    @(negedge clk);
    chk_dut("m", m0, irq, irq_id, busy, acc, we, addr, dat, int'(spur));
    chk_dut("n", m1, n_irq, n_id, n_busy, n_acc, n_we, n_addr, n_dat, int'(n_spur));
  endtask

  task automatic serve(input logic [31:0] p, input int exp_id, input bit chk_ne);
    picsr = p; ack = 0; eoi = 0; bak = 0;
    cyc();
    check("srv_irq", 32'(irq), 32'h1);
    check("srv_id", 32'(irq_id), 32'(exp_id));
    ack = 1; cyc(); ack = 0;
    check("srv_ack_irq", 32'(irq), 32'h0);
    eoi = 1; cyc(); eoi = 0;
    check("srv_clr_dat", dat, 32'h1 << exp_id);
    if (chk_ne) begin
      check("ne_eoi_busy", 32'(n_busy), 32'h0);
      check("ne_eoi_acc", 32'(n_acc), 32'h0);
    end
    bak = 1; cyc(); bak = 0;
    check("srv_done_busy", 32'(busy), 32'h0);
  endtask

  typedef struct {
    logic [31:0] picsr;
    bit          ack, eoi, bak;
    bit          e_irq;
    int          e_id;
    bit          e_busy, e_acc;
    logic [31:0] e_dat;
    int          e_spur;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_ids[3];

    tbl[0]  = '{32'h90, 0, 0, 0, 1, 4, 1, 0, 32'h0,  0};
    tbl[1]  = '{32'h90, 1, 0, 0, 0, 4, 1, 0, 32'h0,  0};
    tbl[2]  = '{32'h90, 0, 1, 0, 0, 4, 1, 1, 32'h10, 0};
    tbl[3]  = '{32'h90, 0, 0, 0, 0, 4, 1, 1, 32'h10, 0};
    tbl[4]  = '{32'h80, 0, 0, 1, 0, 4, 0, 0, 32'h0,  0};
    tbl[5]  = '{32'h0,  0, 0, 0, 0, 4, 0, 0, 32'h0,  0};
    tbl[6]  = '{32'h10, 0, 0, 0, 1, 4, 1, 0, 32'h0,  0};
    tbl[7]  = '{32'h0,  0, 0, 0, 0, 4, 0, 0, 32'h0,  1};
    tbl[8]  = '{32'h10, 0, 0, 0, 1, 4, 1, 0, 32'h0,  1};
    tbl[9]  = '{32'h0,  1, 0, 0, 0, 4, 1, 0, 32'h0,  1};
    tbl[10] = '{32'h0,  1, 0, 0, 0, 4, 1, 0, 32'h0,  1};
    tbl[11] = '{32'h0,  0, 1, 0, 0, 4, 1, 1, 32'h10, 1};
    tbl[12] = '{32'h0,  0, 0, 1, 0, 4, 0, 0, 32'h0,  1};
    tbl[13] = '{32'h0,  0, 1, 0, 0, 4, 0, 0, 32'h0,  1};

    m0 = '{S_IDLE, 0, 0, 0};
    m1 = '{S_IDLE, 0, 0, 0};
    rst = 1; picsr = 32'hFFFF_FFFF; ack = 1; eoi = 1; bak = 1;
    cyc(); cyc();
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_dat", dat, 32'h0);
    rst = 0; picsr = 0; ack = 0; eoi = 0; bak = 0;
    cyc();

    for (int i = 0; i < NV; i++) begin
      picsr = tbl[i].picsr; ack = tbl[i].ack; eoi = tbl[i].eoi; bak = tbl[i].bak;
      cyc();
      check($sformatf("tbl%0d_irq", i),  32'(irq),  32'(tbl[i].e_irq));
      check($sformatf("tbl%0d_id", i),   32'(irq_id), 32'(tbl[i].e_id));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_acc", i),  32'(acc),  32'(tbl[i].e_acc));
      check($sformatf("tbl%0d_addr", i), 32'(addr), tbl[i].e_acc ? 32'h4802 : 32'h0);
      check($sformatf("tbl%0d_dat", i),  dat,       tbl[i].e_dat);
      check($sformatf("tbl%0d_spur", i), 32'(spur), 32'(tbl[i].e_spur));
    end
    ack = 0; eoi = 0; bak = 0; picsr = 0;

    // Arbitration with the lowest and highest lines held pending.
    rst = 1; cyc(); rst = 0;
`ifdef PIC_SCHED_RR_EN
    exp_ids = '{0, 31, 0};
`else
    exp_ids = '{0, 0, 0};
`endif
    for (int g = 0; g < 3; g++) serve(32'h8000_0001, exp_ids[g], g == 0);

    // Slow SPR slave: the clear write must hold steady until acknowledged.
    picsr = 32'h400;
    cyc(); check("slow_id", 32'(irq_id), 32'd10);
    ack = 1; cyc(); ack = 0;
    eoi = 1; cyc(); eoi = 0;
    for (int w = 0; w < 5; w++) begin
      cyc();
      check("slow_acc", 32'(acc), 32'h1);
      check("slow_we", 32'(we), 32'h1);
      check("slow_addr", 32'(addr), 32'h4802);
      check("slow_dat", dat, 32'h400);
    end
    bak = 1; cyc(); bak = 0;
    check("slow_done_busy", 32'(busy), 32'h0);
    check("slow_done_acc", 32'(acc), 32'h0);

    // Reset in the middle of the clear write.
    picsr = 32'h4;
    cyc(); ack = 1; cyc(); ack = 0; eoi = 1; cyc(); eoi = 0;
    check("pre_rst_acc", 32'(acc), 32'h1);
    rst = 1; cyc(); rst = 0;
    check("mid_rst_acc", 32'(acc), 32'h0);
    check("mid_rst_we", 32'(we), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_spur", 32'(spur), 32'h0);
    cyc();
    check("post_rst_irq", 32'(irq), 32'h1);
    check("post_rst_id", 32'(irq_id), 32'd2);
    picsr = 0; cyc();
    check("post_rst_wd_spur", 32'(spur), 32'h1);

    for (int c = 0; c < 2500; c++) begin
      int r;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0) picsr = 0;
        else if (r == 1) picsr = 32'h1 << $urandom_range(0, 31);
        else picsr = $urandom & $urandom & $urandom;
      end
      ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      bak = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
